// File: rtl/gearbox_24_32_if.sv
// Stream bundle for the 24-to-32 packing gearbox: 24-bit input side and
// 32-bit output side with byte-valid mask and frame marker.
interface gearbox_24_32_if;
  logic [23:0] data_in;
  logic        data_in_en;
  logic        data_in_last;
  logic        data_in_rdy;
  logic        data_in_drop;
  logic [31:0] data_out;
  logic        data_out_en;
  logic        data_out_last;
  logic [3:0]  data_out_keep;

  // Gearbox view: consumes the 24-bit stream, produces the 32-bit stream.
  modport slave (
    input  data_in, data_in_en, data_in_last,
    output data_in_rdy, data_in_drop,
    output data_out, data_out_en, data_out_last, data_out_keep
  );

  // Environment view: drives the 24-bit stream, observes the 32-bit stream.
  modport master (
    output data_in, data_in_en, data_in_last,
    input  data_in_rdy, data_in_drop,
    input  data_out, data_out_en, data_out_last, data_out_keep
  );
endinterface

// File: rtl/gearbox_24_32.sv
// Packs 24-bit words (LSB byte first) into 32-bit words; a frame-closing word
// flushes the residual bytes as a zero-padded word with a byte-valid mask.
module gearbox_24_32 (
  input  logic            clk,
  input  logic            reset_n,
  gearbox_24_32_if.slave  bus
);

  typedef enum logic [2:0] {
    P0    = 3'd0,
    P1    = 3'd1,
    P2    = 3'd2,
    P3    = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] res_q, res_d;
  logic [3:0]  fkeep_q, fkeep_d;
  logic [31:0] dout_q, dout_d;
  logic        en_q, en_d;
  logic        last_q, last_d;
  logic [3:0]  keep_q, keep_d;
  logic        rdy_q, rdy_d;
  logic        drop_q, drop_d;
  logic        accept;

  assign accept = bus.data_in_en & rdy_q;

  // Next-state, residual and output-word selection.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    fkeep_d = fkeep_q;
    dout_d  = dout_q;
    keep_d  = keep_q;
    en_d    = 1'b0;
    last_d  = 1'b0;
    drop_d  = bus.data_in_en & ~rdy_q;
    case (state_q)
      P0: begin
        if (accept) begin
          if (bus.data_in_last) begin
            dout_d  = {8'h00, bus.data_in};
            keep_d  = 4'h7;
            en_d    = 1'b1;
            last_d  = 1'b1;
            res_d   = 24'h000000;
            state_d = P0;
          end else begin
            res_d   = bus.data_in;
            state_d = P1;
          end
        end else begin
          state_d = P0;
        end
      end
      P1: begin
        if (accept) begin
          dout_d = {bus.data_in[7:0], res_q};
          keep_d = 4'hF;
          en_d   = 1'b1;
          res_d  = {8'h00, bus.data_in[23:8]};
          if (bus.data_in_last) begin
            fkeep_d = 4'h3;
            state_d = FLUSH;
          end else begin
            state_d = P2;
          end
        end else begin
          state_d = P1;
        end
      end
      P2: begin
        if (accept) begin
          dout_d = {bus.data_in[15:0], res_q[15:0]};
          keep_d = 4'hF;
          en_d   = 1'b1;
          res_d  = {16'h0000, bus.data_in[23:16]};
          if (bus.data_in_last) begin
            fkeep_d = 4'h1;
            state_d = FLUSH;
          end else begin
            state_d = P3;
          end
        end else begin
          state_d = P2;
        end
      end
      P3: begin
        if (accept) begin
          dout_d  = {bus.data_in, res_q[7:0]};
          keep_d  = 4'hF;
          en_d    = 1'b1;
          last_d  = bus.data_in_last;
          res_d   = 24'h000000;
          state_d = P0;
        end else begin
          state_d = P3;
        end
      end
      FLUSH: begin
        // Residual is kept right-aligned with zero upper bytes, so it pads itself.
        dout_d  = {8'h00, res_q};
        keep_d  = fkeep_q;
        en_d    = 1'b1;
        last_d  = 1'b1;
        res_d   = 24'h000000;
        state_d = P0;
      end
      default: begin
        res_d   = 24'h000000;
        state_d = P0;
      end
    endcase
    rdy_d = (state_d != FLUSH);
  end

  // State, residual and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= P0;
      res_q   <= 24'h000000;
      fkeep_q <= 4'h0;
      dout_q  <= 32'h00000000;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
      keep_q  <= 4'h0;
      rdy_q   <= 1'b1;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      fkeep_q <= fkeep_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      last_q  <= last_d;
      keep_q  <= keep_d;
      rdy_q   <= rdy_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.data_out      = dout_q;
  assign bus.data_out_en   = en_q;
  assign bus.data_out_last = last_q;
  assign bus.data_out_keep = keep_q;
  assign bus.data_in_rdy   = rdy_q;
  assign bus.data_in_drop  = drop_q;

endmodule

// File: tb/tb_gearbox_24_32.sv
// Scoreboard bench for gearbox_24_32: directed frames push expected output
// words; a negedge monitor pops and compares whenever data_out_en is high.
module tb_gearbox_24_32;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  gearbox_24_32_if bus ();

  gearbox_24_32 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Accepted-word monitor: every output word must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && bus.data_out_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", bus.data_out, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", bus.data_out, e.data);
        chk("out_keep", {28'h0, bus.data_out_keep}, {28'h0, e.keep});
        chk("out_last", {31'h0, bus.data_out_last}, {31'h0, e.last});
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [23:0] d, input logic l);
    bus.data_in      = d;
    bus.data_in_en   = 1'b1;
    bus.data_in_last = l;
    @(posedge clk);
    #1;
    bus.data_in_en   = 1'b0;
    bus.data_in_last = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, bus.data_out, 32'h00000000);
    chk({tag, "_en"},   {31'h0, bus.data_out_en}, 32'h0);
    chk({tag, "_last"}, {31'h0, bus.data_out_last}, 32'h0);
    chk({tag, "_keep"}, {28'h0, bus.data_out_keep}, 32'h0);
    chk({tag, "_rdy"},  {31'h0, bus.data_in_rdy}, 32'h1);
    chk({tag, "_drop"}, {31'h0, bus.data_in_drop}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b1;
    bus.data_in = 24'h000000;
    bus.data_in_en = 1'b0;
    bus.data_in_last = 1'b0;
    #2 reset_n = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    #3 reset_n = 1'b1;
    idle(1);

    // Continuous packing with data_out_en pattern 0,1,1,1.
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h08070605, 4'hF, 1'b0);
    expect_word(32'h0C0B0A09, 4'hF, 1'b0);
    send(24'h030201, 1'b0);
    chk("cont_en0", {31'h0, bus.data_out_en}, 32'h0);
    send(24'h060504, 1'b0);
    chk("cont_en1", {31'h0, bus.data_out_en}, 32'h1);
    send(24'h090807, 1'b0);
    chk("cont_en2", {31'h0, bus.data_out_en}, 32'h1);
    send(24'h0C0B0A, 1'b0);
    chk("cont_en3", {31'h0, bus.data_out_en}, 32'h1);
    idle(1);
    chk("cont_idle_en", {31'h0, bus.data_out_en}, 32'h0);

    // Last in P1: full word then flush word, ready low one cycle.
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h00000605, 4'h3, 1'b1);
    send(24'h030201, 1'b0);
    send(24'h060504, 1'b1);
    chk("p1last_rdy_low", {31'h0, bus.data_in_rdy}, 32'h0);
    idle(1);
    chk("p1last_rdy_back", {31'h0, bus.data_in_rdy}, 32'h1);
    chk("p1last_flush_en", {31'h0, bus.data_out_en}, 32'h1);
    idle(1);

    // Last in P0: single-word frame.
    expect_word(32'h00AABBCC, 4'h7, 1'b1);
    send(24'hAABBCC, 1'b1);
    chk("p0last_rdy", {31'h0, bus.data_in_rdy}, 32'h1);

    // Last in P3: four-word frame, ready never drops.
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h08070605, 4'hF, 1'b0);
    expect_word(32'h0C0B0A09, 4'hF, 1'b1);
    send(24'h030201, 1'b0);
    chk("p3f_rdy0", {31'h0, bus.data_in_rdy}, 32'h1);
    send(24'h060504, 1'b0);
    chk("p3f_rdy1", {31'h0, bus.data_in_rdy}, 32'h1);
    send(24'h090807, 1'b0);
    chk("p3f_rdy2", {31'h0, bus.data_in_rdy}, 32'h1);
    send(24'h0C0B0A, 1'b1);
    chk("p3f_rdy3", {31'h0, bus.data_in_rdy}, 32'h1);
    idle(1);

    // Last in P2, then data_in_en held high through FLUSH.
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h08070605, 4'hF, 1'b0);
    expect_word(32'h00000009, 4'h1, 1'b1);
    expect_word(32'h33222222, 4'hF, 1'b0);
    expect_word(32'h00003333, 4'h3, 1'b1);
    send(24'h030201, 1'b0);
    send(24'h060504, 1'b0);
    send(24'h090807, 1'b1);
    bus.data_in    = 24'h111111;
    bus.data_in_en = 1'b1;
    @(posedge clk);
    #1;
    chk("drop_pulse", {31'h0, bus.data_in_drop}, 32'h1);
    bus.data_in = 24'h222222;
    @(posedge clk);
    #1;
    chk("drop_cleared", {31'h0, bus.data_in_drop}, 32'h0);
    bus.data_in_en = 1'b0;
    send(24'h333333, 1'b1);
    idle(2);

    // Gapped 12-word frame: bytes 1..36 in order.
    for (int k = 0; k < 9; k++) begin
      logic [7:0] b;
      b = 8'(4 * k + 1);
      expect_word({b + 8'd3, b + 8'd2, b + 8'd1, b}, 4'hF, (k == 8) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      b = 8'(3 * i + 1);
      send({b + 8'd2, b + 8'd1, b}, (i == 11) ? 1'b1 : 1'b0);
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);

    // Reset while in P2.
    expect_word(32'h04030201, 4'hF, 1'b0);
    send(24'h030201, 1'b0);
    send(24'h060504, 1'b0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_p2");
    idle(1);
    #2 reset_n = 1'b1;
    idle(1);
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h08070605, 4'hF, 1'b0);
    expect_word(32'h00000009, 4'h1, 1'b1);
    send(24'h030201, 1'b0);
    send(24'h060504, 1'b0);
    send(24'h090807, 1'b1);
    idle(2);

    // Reset while in FLUSH: the pending flush word is lost.
    expect_word(32'h04030201, 4'hF, 1'b0);
    send(24'h030201, 1'b0);
    send(24'h060504, 1'b1);
    chk("rst_fl_pre_rdy", {31'h0, bus.data_in_rdy}, 32'h0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_flush");
    idle(1);
    #2 reset_n = 1'b1;
    idle(1);
    expect_word(32'h04030201, 4'hF, 1'b0);
    expect_word(32'h00000605, 4'h3, 1'b1);
    send(24'h030201, 1'b0);
    send(24'h060504, 1'b1);
    idle(3);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gearbox_24_32.md
# gearbox_24_32

Single-clock 24-bit to 32-bit width converter: packs a stream of 24-bit words, least-significant byte first, into 32-bit words. It is the packing counterpart of the 32-to-24 gearbox and sits on the transmit side, ahead of any 32-bit clock-crossing FIFO. A `data_in_last` marker closes a frame. The residual bytes are flushed as a zero-padded final word with a byte-valid mask, and packing restarts aligned for the next frame.

## Interface
- No parameters; widths are fixed at 24 in and 32 out.
- `clk`  in  1  Sole clock; all logic on its rising edge.
- `reset_n`  in  1  Asynchronous, active-low reset.
- `data_in`  in  24  Input word; byte 0 = `[7:0]` is first on the wire.
- `data_in_en`  in  1  Input valid. A transfer is accepted when `data_in_en & data_in_rdy`.
- `data_in_last`  in  1  Marks the final word of a frame. Qualified by an accepted transfer; ignored otherwise.
- `data_in_rdy`  out  1  Block can accept input this cycle.
- `data_in_drop`  out  1  One-cycle pulse: `data_in_en` was high while `data_in_rdy` was low, and that word was discarded.
- `data_out`  out  32  Packed output word; byte lanes not valid per `data_out_keep` are 0.
- `data_out_en`  out  1  `data_out` valid this cycle.
- `data_out_last`  out  1  Final word of a frame; only high with `data_out_en`.
- `data_out_keep`  out  4  Byte-valid mask. It is 4'hF except on a last word.

## Operation
- **State machine:** P0, P1, P2, P3, FLUSH. The phase Pn equals the number of input words accepted in the current 4-in/3-out group.
- **Residual register:** 24 bits. Bytes held per phase are P0=0, P1=3, P2=2, P3=1, all right-aligned.
- **Accepted word, not last:**
  - P0: store `in` into the residual; no output; go to P1.
  - P1: emit `{in[7:0], res[23:0]}`; residual = `in[23:8]`; go to P2.
  - P2: emit `{in[15:0], res[15:0]}`; residual = `in[23:16]`; go to P3.
  - P3: emit `{in[23:0], res[7:0]}`; residual = 0; go to P0.
- **Accepted word with last:**
  - P0: emit `{8'h0, in}`, keep 4'h7, last; go to P0.
  - P1: emit the P1 word with keep F and last=0. Then go to FLUSH with residual `in[23:8]`, flush keep 4'h3.
  - P2: emit the P2 word with keep F and last=0. Then go to FLUSH with residual `in[23:16]`, flush keep 4'h1.
  - P3: emit the P3 word, keep F, last; go to P0.
- **FLUSH:** emit `{zero pad, residual}` with the stored keep and last=1; clear the residual; go to P0.
- **Ready:** `data_in_rdy = (state != FLUSH)`, registered.
  - Data offered during FLUSH is discarded, the phase is unchanged, and `data_in_drop` pulses.
- **Idle cycles:** `data_in_en` low holds the state and residual indefinitely. No timeout flush.
- **Reset mid-frame:** the residual and any pending flush are lost. State returns to P0 and no last word is emitted.

## Timing
- **Reset values:** `data_out`=0, `data_out_en`=0, `data_out_last`=0, `data_out_keep`=0, `data_in_rdy`=1, `data_in_drop`=0, state=P0, residual=0.
- **Outputs:** all outputs are registered. When `data_out_en`=0, `data_out`, `data_out_keep` and `data_out_last` hold their previous values, except `data_out_last`, which is 0.
- **Latency:** an accepted word at edge N produces its output word at edge N+1.
  - For a last word in P1 or P2, the full word appears at N+1 and the flush word at N+2.
  - `data_in_rdy` is low only during the cycle between N+1 and N+2.
- **Throughput:** continuous input of 4 words gives 3 outputs. `data_out_en` is low in the cycle after each P0 acceptance.
- **Frame turnaround:** a new frame may start on the cycle after the last accepted word in P0 or P3, and one cycle later from P1 or P2.
- **`data_in_drop`:** asserted at the edge following the offending cycle.

## Test plan
- **Continuous packing:** reset, then inputs 0x030201, 0x060504, 0x090807, 0x0C0B0A back-to-back.
  - Outputs 0x04030201, 0x08070605, 0x0C0B0A09 with keep F and no last.
  - `data_out_en` pattern 0,1,1,1.
- **Last in P1:** inputs 0x030201, 0x060504(last).
  - Outputs 0x04030201 with keep F, last=0, then 0x00000605 with keep 3, last=1.
  - `data_in_rdy` low for exactly 1 cycle.
- **Last in P0 and P3:**
  - A single word 0xAABBCC(last) outputs 0x00AABBCC with keep 7, last=1.
  - A 4-word frame ending with last outputs 3 words, the third with last and keep F, and `data_in_rdy` never drops.
- **Drop during FLUSH:** a last in P2, then `data_in_en` held high.
  - The word offered during FLUSH is dropped with a `data_in_drop` pulse.
  - The next word is accepted as P0 of the new frame; verify its alignment on the following output.
- **Gapped input:** random `data_in_en` gaps in a 12-word frame. The output byte stream is identical to the gap-free case.
- **Reset mid-frame:** deassert `reset_n` asynchronously while in P2 (and in another run while in FLUSH).
  - All outputs go to their reset values immediately.
  - After release, 0x030201, 0x060504 packs as 0x04030201, proving the residual was cleared.
